// File: rtl/lgu_pkg.sv
// Shared types and the per-bit operator for the logic gate unit.
package lgu_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_PASS = 3'd6,
    OP_NOT  = 3'd7
  } lgu_op_e;

  typedef enum logic {
    MODE_PAIR = 1'b0,
    MODE_FOLD = 1'b1
  } lgu_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } lgu_state_e;

  // Single-bit evaluation; every op is bitwise, so a word is just this per lane.
  function automatic logic lgu_apply(lgu_op_e op, logic a, logic b);
    logic r;
    r = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_PASS: r = a;
      OP_NOT:  r = ~a;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lgu_op_core.sv
// Combinational WIDTH-bit evaluator: applies lgu_apply lane by lane.
module lgu_op_core
  import lgu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  lgu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    for (int i = 0; i < WIDTH; i++) begin
      y[i] = lgu_apply(op, a[i], b[i]);
    end
  end

endmodule

// File: rtl/logic_gate_unit.sv
// Registered WIDTH-bit logic unit with PAIR/FOLD modes and valid/ready on both sides.
// Optional result handshake counter enabled by defining LGU_PERF_CNT_EN.
module logic_gate_unit
  import lgu_pkg::*;
#(
  parameter int WIDTH = 8
`ifdef LGU_PERF_CNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero
`ifdef LGU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] result_count
`endif
);

  lgu_state_e       state;
  lgu_op_e          op_reg;
  logic [WIDTH-1:0] acc;

  lgu_op_e          op_in;
  lgu_mode_e        mode_in;
  lgu_op_e          core_op;
  logic [WIDTH-1:0] core_a;
  logic [WIDTH-1:0] core_b;
  logic [WIDTH-1:0] core_y;
  logic             accept;

  assign op_in    = lgu_op_e'(in_op);
  assign mode_in  = lgu_mode_e'(in_mode);
  assign in_ready = (state != ST_OUT) | out_ready;
  assign accept   = in_valid & in_ready;

  // A fold's first beat passes through (or inverts for NOT); NOT never looks at acc.
  always_comb begin
    core_op = op_in;
    core_a  = in_a;
    core_b  = in_b;
    if (state == ST_ACC) begin
      core_op = op_reg;
      core_a  = (op_reg == OP_NOT) ? in_a : acc;
      core_b  = in_a;
    end else if (mode_in == MODE_FOLD) begin
      core_op = (op_in == OP_NOT) ? OP_NOT : OP_PASS;
      core_a  = in_a;
      core_b  = in_a;
    end
  end

  lgu_op_core #(.WIDTH(WIDTH)) u_core (
    .op (core_op),
    .a  (core_a),
    .b  (core_b),
    .y  (core_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_zero  <= 1'b1;
      acc       <= '0;
      op_reg    <= OP_AND;
    end else begin
      case (state)
        ST_ACC: begin
          if (in_valid) begin
            acc <= core_y;
            if (in_last) begin
              out_y     <= core_y;
              out_zero  <= ~|core_y;
              out_valid <= 1'b1;
              state     <= ST_OUT;
            end
          end
        end
        default: begin
          // OUT drains first; an accepted beat in the same cycle overrides below.
          if (state == ST_OUT && out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
          if (accept) begin
            if (mode_in == MODE_PAIR) begin
              out_y     <= core_y;
              out_zero  <= ~|core_y;
              out_valid <= 1'b1;
              state     <= ST_OUT;
            end else begin
              op_reg <= op_in;
              acc    <= in_a;
              if (in_last) begin
                out_y     <= core_y;
                out_zero  <= ~|core_y;
                out_valid <= 1'b1;
                state     <= ST_OUT;
              end else begin
                state <= ST_ACC;
              end
            end
          end
        end
      endcase
    end
  end

`ifdef LGU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_count <= '0;
    end else if (out_valid && out_ready && (result_count != '1)) begin
      result_count <= result_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_logic_gate_unit.sv
// Directed plus randomized bench for logic_gate_unit (WIDTH=8) with a word-level reference model.
module tb_logic_gate_unit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [2:0] in_op;
  logic       in_mode;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_y;
  logic       out_zero;
`ifdef LGU_PERF_CNT_EN
  logic [15:0] result_count;
  int          cnt_model;
`endif

  int n_vec;
  int n_err;

  logic [7:0] exp_q[$];
  logic [7:0] beats[$];
  int         fold_op;

  logic [7:0] r1;
  logic [7:0] r2;

  logic_gate_unit #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_mode   (in_mode),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_zero  (out_zero)
`ifdef LGU_PERF_CNT_EN
    ,
    .result_count (result_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_op(int op, logic [7:0] a, logic [7:0] b);
    case (op)
      0:       return a & b;
      1:       return a | b;
      2:       return ~(a & b);
      3:       return ~(a | b);
      4:       return a ^ b;
      5:       return ~(a ^ b);
      6:       return a;
      default: return ~a;
    endcase
  endfunction

  task automatic check8(string tag, logic [7:0] obs, logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(string tag, logic obs, logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference: PAIR gives op(a,b); FOLD reduces the group's beats left to right.
  task automatic model_in(int op, logic mode, logic last, logic [7:0] a, logic [7:0] b);
    logic [7:0] r;
    if (beats.size() == 0 && mode == 1'b0) begin
      exp_q.push_back(ref_op(op, a, b));
    end else begin
      if (beats.size() == 0) fold_op = op;
      beats.push_back(a);
      if (last) begin
        if (fold_op == 7) begin
          r = ~a;
        end else begin
          r = beats[0];
          for (int i = 1; i < beats.size(); i++) r = ref_op(fold_op, r, beats[i]);
        end
        exp_q.push_back(r);
        beats.delete();
      end
    end
  endtask

  task automatic drive(logic v, logic [2:0] op, logic mode, logic last,
                       logic [7:0] a, logic [7:0] b);
    in_valid = v;
    in_op    = op;
    in_mode  = mode;
    in_last  = last;
    in_a     = a;
    in_b     = b;
  endtask

  task automatic tick();
    logic       fi;
    logic       fo;
    logic       hold;
    logic [7:0] y_prev;
    logic [7:0] e;
    #1;
    fi     = in_valid & in_ready & rst_n;
    fo     = out_valid & out_ready & rst_n;
    hold   = out_valid & ~out_ready & rst_n;
    y_prev = out_y;
    if (fo) begin
      if (exp_q.size() == 0) begin
        check1("spurious_out", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check8("sb_out_y", out_y, e);
        check1("sb_out_zero", out_zero, (e == 8'h00));
      end
    end
    if (fi) model_in(int'(in_op), in_mode, in_last, in_a, in_b);
    if (!rst_n) begin
      exp_q.delete();
      beats.delete();
    end
`ifdef LGU_PERF_CNT_EN
    if (!rst_n) cnt_model = 0;
    else if (fo && cnt_model < 65535) cnt_model++;
`endif
    @(posedge clk);
    #1;
    if (hold) begin
      check1("hold_valid", out_valid, 1'b1);
      check8("hold_y", out_y, y_prev);
    end
`ifdef LGU_PERF_CNT_EN
    check8("cnt_lo", result_count[7:0], 8'(cnt_model));
    check8("cnt_hi", result_count[15:8], 8'(cnt_model >> 8));
`endif
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    fold_op = 0;
`ifdef LGU_PERF_CNT_EN
    cnt_model = 0;
`endif
    rst_n = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    check1("rst_out_valid", out_valid, 1'b0);
    check8("rst_out_y", out_y, 8'h00);
    check1("rst_out_zero", out_zero, 1'b1);
    check1("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    // PAIR NOR 0F,33
    out_ready = 1'b1;
    drive(1'b1, 3'd3, 1'b0, 1'b0, 8'h0F, 8'h33);
    tick();
    drive(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    check1("nor_valid", out_valid, 1'b1);
    check8("nor_y", out_y, 8'hC0);
    check1("nor_zero", out_zero, 1'b0);
    tick();

    // All eight ops back to back
    for (int op = 0; op < 8; op++) begin
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      drive(1'b1, 3'(op), 1'b0, 1'($urandom), r1, r2);
      tick();
      check1("b2b_valid", out_valid, 1'b1);
      check1("b2b_in_ready", in_ready, 1'b1);
      check8("b2b_y", out_y, ref_op(op, r1, r2));
    end
    drive(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();

    // PAIR NOR FF,00 gives zero
    drive(1'b1, 3'd3, 1'b0, 1'b0, 8'hFF, 8'h00);
    tick();
    drive(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    check8("nor0_y", out_y, 8'h00);
    check1("nor0_zero", out_zero, 1'b1);
    tick();

    // FOLD XOR 01,02,04; middle beats carry junk op/mode
    drive(1'b1, 3'd4, 1'b1, 1'b0, 8'h01, 8'hAA);
    tick();
    check1("fxor_gap1", out_valid, 1'b0);
    drive(1'b1, 3'd0, 1'b0, 1'b0, 8'h02, 8'h55);
    tick();
    check1("fxor_gap2", out_valid, 1'b0);
    drive(1'b0, 3'd1, 1'b0, 1'b1, 8'hFF, 8'h00);
    tick();
    check1("fxor_idle", out_valid, 1'b0);
    drive(1'b1, 3'd2, 1'b1, 1'b1, 8'h04, 8'h00);
    tick();
    drive(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    check1("fxor_valid", out_valid, 1'b1);
    check8("fxor_y", out_y, 8'h07);
    tick();

    // FOLD NOR 0F,F0
    drive(1'b1, 3'd3, 1'b1, 1'b0, 8'h0F, 8'h00);
    tick();
    drive(1'b1, 3'd3, 1'b1, 1'b1, 8'hF0, 8'h00);
    tick();
    drive(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    check8("fnor_y", out_y, 8'h00);
    check1("fnor_zero", out_zero, 1'b1);
    tick();

    // Backpressure with a second beat pending
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 1'b0, 1'b0, 8'h3C, 8'h0F);
    tick();
    drive(1'b1, 3'd1, 1'b0, 1'b0, 8'h50, 8'h05);
    for (int k = 0; k < 5; k++) begin
      tick();
      check1("bp_in_ready", in_ready, 1'b0);
      check8("bp_y", out_y, 8'h0C);
    end
    out_ready = 1'b1;
    tick();
    drive(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    check1("bp_handoff_valid", out_valid, 1'b1);
    check8("bp_handoff_y", out_y, 8'h55);
    tick();
    check1("bp_drained", out_valid, 1'b0);

    // Reset in the middle of a fold
    drive(1'b1, 3'd0, 1'b1, 1'b0, 8'h0F, 8'h00);
    tick();
    drive(1'b1, 3'd0, 1'b1, 1'b0, 8'h3C, 8'h00);
    tick();
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    rst_n = 1'b1;
    check1("rmf_valid", out_valid, 1'b0);
    drive(1'b1, 3'd1, 1'b1, 1'b1, 8'hA0, 8'h00);
    tick();
    drive(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    check1("rmf_out_valid", out_valid, 1'b1);
    check8("rmf_y", out_y, 8'hA0);
    tick();

    // Randomized traffic with gaps, backpressure and occasional reset
    for (int c = 0; c < 600; c++) begin
      rst_n     = ($urandom_range(99) != 0);
      out_ready = ($urandom_range(2) != 0);
      drive(($urandom_range(3) != 0), 3'($urandom), 1'($urandom),
            ($urandom_range(2) == 0), 8'($urandom), 8'($urandom));
      tick();
    end

    // Close any open fold group, then drain
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 3'd5, 1'b0, 1'b1, 8'($urandom), 8'($urandom));
    tick();
    drive(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int k = 0; k < 4; k++) tick();
    check1("drain_queue_empty", (exp_q.size() == 0), 1'b1);
    check1("drain_no_open_fold", (beats.size() == 0), 1'b1);
    check1("drain_out_valid", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
